// File: rtl/entity_slot_scheduler.sv
// Entity descriptor scheduler: round-robin writes into shadow slots, frame-synchronous copy to active slots.
// Define ENTITY_SCHED_STATS_EN to add the saturating drop_count output.
module entity_slot_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_SLOTS = 9,
  parameter int ENTITY_W  = 14,
  parameter int IDX_W     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*IDX_W-1:0]      req_slot,
  input  logic [NUM_REQ*ENTITY_W-1:0]   req_data,
  input  logic                          frame_start,
  input  logic                          clear_all,
  output logic [NUM_SLOTS*ENTITY_W-1:0] entity_out,
  output logic                          commit_busy,
  output logic                          bad_slot_err,
  output logic                          overrun
`ifdef ENTITY_SCHED_STATS_EN
  ,
  output logic [7:0]                    drop_count
`endif
);

  localparam int RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [ENTITY_W-1:0] SLOT_RESET = {4'hF, {(ENTITY_W-4){1'b0}}};

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_COMMIT = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [CNT_W-1:0]      r_idx;
  logic [RR_W-1:0]       r_rr;
  logic [ENTITY_W-1:0]   r_shadow [NUM_SLOTS];
  logic [ENTITY_W-1:0]   r_active [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]  r_dirty;
  logic                  r_bad_slot;
  logic                  r_overrun;

  logic [2*NUM_REQ-1:0]  w_valid_dbl;
  logic [NUM_REQ-1:0]    w_valid_rot;
  logic [RR_W-1:0]       w_grant_off;
  logic [RR_W-1:0]       w_grant_idx;
  logic                  w_grant_found;
  logic                  w_xfer;
  logic [IDX_W-1:0]      w_sel_slot;
  logic [CNT_W-1:0]      w_sel_idx;
  logic [ENTITY_W-1:0]   w_sel_data;
  logic                  w_slot_ok;
  logic                  w_drop;

  // Rotate the request vector so bit 0 is the requester at the round-robin pointer.
  assign w_valid_dbl = {req_valid, req_valid};
  assign w_valid_rot = w_valid_dbl[r_rr +: NUM_REQ];

  always_comb begin
    w_grant_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_valid_rot[k]) begin
        w_grant_off = RR_W'(k);
      end else begin
        w_grant_off = w_grant_off;
      end
    end
  end

  assign w_grant_found = |req_valid;
  assign w_grant_idx   = RR_W'((int'(r_rr) + int'(w_grant_off)) % NUM_REQ);
  assign w_xfer        = rst_n && (r_state == ST_IDLE) && !frame_start && !clear_all && w_grant_found;
  assign w_sel_slot    = req_slot[int'(w_grant_idx)*IDX_W +: IDX_W];
  assign w_sel_data    = req_data[int'(w_grant_idx)*ENTITY_W +: ENTITY_W];
  assign w_sel_idx     = CNT_W'(w_sel_slot);
  assign w_slot_ok     = (32'(w_sel_slot) < $unsigned(NUM_SLOTS));
  assign w_drop        = (r_state == ST_COMMIT) && frame_start;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (frame_start) begin
          w_next_state = ST_COMMIT;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_COMMIT: begin
        if (r_idx == CNT_W'(NUM_SLOTS - 1)) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_COMMIT;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready   = '0;
    commit_busy = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer) begin
          req_ready[w_grant_idx] = 1'b1;
        end else begin
          req_ready = '0;
        end
      end
      ST_COMMIT: commit_busy = 1'b1;
      default: begin
        req_ready   = '0;
        commit_busy = 1'b0;
      end
    endcase
  end

  // Slot storage: frame_start outranks clear_all, which outranks a write transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        r_shadow[s] <= SLOT_RESET;
        r_active[s] <= SLOT_RESET;
      end
      r_dirty <= '0;
      r_rr    <= '0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_idx <= '0;
          if (frame_start) begin
            r_dirty <= r_dirty;
          end else if (clear_all) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
              r_shadow[s][ENTITY_W-1 -: 4] <= 4'hF;
            end
            r_dirty <= '1;
          end else if (w_xfer) begin
            r_rr <= RR_W'((int'(w_grant_idx) + 1) % NUM_REQ);
            if (w_slot_ok) begin
              r_shadow[w_sel_idx] <= w_sel_data;
              r_dirty[w_sel_idx]  <= 1'b1;
            end else begin
              r_dirty <= r_dirty;
            end
          end else begin
            r_dirty <= r_dirty;
          end
        end
        ST_COMMIT: begin
          if (r_dirty[r_idx]) begin
            r_active[r_idx] <= r_shadow[r_idx];
            r_dirty[r_idx]  <= 1'b0;
          end else begin
            r_dirty <= r_dirty;
          end
          r_idx <= r_idx + CNT_W'(1);
        end
        default: r_idx <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bad_slot <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_bad_slot <= r_bad_slot | (w_xfer & ~w_slot_ok);
      r_overrun  <= r_overrun | w_drop;
    end
  end

`ifdef ENTITY_SCHED_STATS_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_drop_cnt <= 8'h00;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'h01;
    end else begin
      r_drop_cnt <= r_drop_cnt;
    end
  end

  assign drop_count = r_drop_cnt;
`endif

  always_comb begin
    entity_out = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      entity_out[s*ENTITY_W +: ENTITY_W] = r_active[s];
    end
  end

  assign bad_slot_err = r_bad_slot;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_entity_slot_scheduler.sv
// Scoreboard bench for entity_slot_scheduler: expected grants and committed frames are queued
// by the stimulus and compared by a negedge monitor.
module tb_entity_slot_scheduler;

  localparam int NUM_REQ   = 4;
  localparam int NUM_SLOTS = 9;
  localparam int ENTITY_W  = 14;
  localparam int IDX_W     = 4;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*IDX_W-1:0]      req_slot;
  logic [NUM_REQ*ENTITY_W-1:0]   req_data;
  logic                          frame_start;
  logic                          clear_all;
  logic [NUM_SLOTS*ENTITY_W-1:0] entity_out;
  logic                          commit_busy;
  logic                          bad_slot_err;
  logic                          overrun;
`ifdef ENTITY_SCHED_STATS_EN
  logic [7:0]                    drop_count;
`endif

  entity_slot_scheduler #(
    .NUM_REQ(NUM_REQ), .NUM_SLOTS(NUM_SLOTS), .ENTITY_W(ENTITY_W), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_slot(req_slot), .req_data(req_data),
    .frame_start(frame_start), .clear_all(clear_all),
    .entity_out(entity_out), .commit_busy(commit_busy),
    .bad_slot_err(bad_slot_err), .overrun(overrun)
`ifdef ENTITY_SCHED_STATS_EN
    , .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_grant_q[$];
  logic [NUM_SLOTS*ENTITY_W-1:0] exp_frame_q[$];
  logic [ENTITY_W-1:0] model [NUM_SLOTS];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [NUM_SLOTS*ENTITY_W-1:0] pack_model();
    logic [NUM_SLOTS*ENTITY_W-1:0] v;
    for (int s = 0; s < NUM_SLOTS; s++) v[s*ENTITY_W +: ENTITY_W] = model[s];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [IDX_W-1:0] slot, input logic [ENTITY_W-1:0] data);
    req_valid[r] = 1'b1;
    req_slot[r*IDX_W +: IDX_W] = slot;
    req_data[r*ENTITY_W +: ENTITY_W] = data;
  endtask

  task automatic reset_model();
    for (int s = 0; s < NUM_SLOTS; s++) model[s] = 14'h3C00;
  endtask

  // Issues a one-cycle frame_start; the committed frame is expected to equal the model.
  task automatic start_commit();
    frame_start = 1'b1;
    exp_frame_q.push_back(pack_model());
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_commit();
    int n = 0;
    while (commit_busy === 1'b1 && n < 30) begin
      tick();
      n++;
    end
    check("commit_timeout", 64'(n < 30), 64'd1);
  endtask

  // Monitor: compares every grant and every completed commit against the queues.
  logic prev_busy = 1'b0;
  int   busy_cnt  = 0;
  int   g;
  logic [NUM_SLOTS*ENTITY_W-1:0] f;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy = 1'b0;
      busy_cnt  = 0;
    end else begin
      if (req_ready != '0) begin
        if (exp_grant_q.size() == 0) begin
          check("unexpected_grant", 64'(req_ready), 64'd0);
        end else begin
          g = exp_grant_q.pop_front();
          check("grant", 64'(req_ready), 64'd1 << g);
        end
      end
      if (commit_busy) busy_cnt++;
      if (prev_busy && !commit_busy) begin
        check("busy_len", 64'(busy_cnt), 64'd9);
        busy_cnt = 0;
        if (exp_frame_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_commit: no frame queued");
        end else begin
          f = exp_frame_q.pop_front();
          for (int s = 0; s < NUM_SLOTS; s++)
            check($sformatf("slot%0d", s), 64'(entity_out[s*ENTITY_W +: ENTITY_W]),
                  64'(f[s*ENTITY_W +: ENTITY_W]));
        end
      end
      prev_busy = commit_busy;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = '0; req_slot = '0; req_data = '0;
    frame_start = 1'b0; clear_all = 1'b0;
    reset_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < NUM_SLOTS; s++)
      check("reset_slot", 64'(entity_out[s*ENTITY_W +: ENTITY_W]), 64'h3C00);
    check("reset_ready", 64'(req_ready), 64'd0);
    check("reset_busy", 64'(commit_busy), 64'd0);
    check("reset_bad", 64'(bad_slot_err), 64'd0);
    check("reset_overrun", 64'(overrun), 64'd0);
    rst_n = 1'b1;

    // Round robin from rr=0 with all requesters holding valid, then wrap to requester 0.
    tick();
    set_req(0, 4'd0, 14'h0101); set_req(1, 4'd1, 14'h0202);
    set_req(2, 4'd3, 14'h0303); set_req(3, 4'd4, 14'h0404);
    for (int i = 0; i < 4; i++) begin
      exp_grant_q.push_back(i);
      tick();
    end
    req_valid = 4'b0001;
    set_req(0, 4'd6, 14'h1166);
    exp_grant_q.push_back(0);
    tick();
    req_valid = '0;
    model[0] = 14'h0101; model[1] = 14'h0202; model[3] = 14'h0303;
    model[4] = 14'h0404; model[6] = 14'h1166;

    // Requester 1 writes slot 2; active view must not change before the commit.
    set_req(1, 4'd2, 14'h0512);
    exp_grant_q.push_back(1);
    tick();
    req_valid = '0;
    model[2] = 14'h0512;
    @(negedge clk);
    check("slot2_before_commit", 64'(entity_out[2*ENTITY_W +: ENTITY_W]), 64'h3C00);
    tick();
    start_commit();
    wait_commit();

    // Out-of-range slot index: accepted, flagged, discarded.
    set_req(2, 4'd12, 14'h1234);
    exp_grant_q.push_back(2);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("bad_slot_err", 64'(bad_slot_err), 64'd1);
    check("overrun_clear", 64'(overrun), 64'd0);
    tick();
    start_commit();
    wait_commit();

    // frame_start + valid + clear_all together, then frame_start during COMMIT.
    frame_start = 1'b1; clear_all = 1'b1;
    set_req(0, 4'd7, 14'h2222);
    exp_frame_q.push_back(pack_model());
    @(negedge clk);
    check("ready_in_frame_start", 64'(req_ready), 64'd0);
    tick();
    frame_start = 1'b0; clear_all = 1'b0; req_valid = '0;
    tick();
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wait_commit();
    @(negedge clk);
    check("overrun_set", 64'(overrun), 64'd1);
    check("bad_sticky", 64'(bad_slot_err), 64'd1);
`ifdef ENTITY_SCHED_STATS_EN
    check("drop_count", 64'(drop_count), 64'd1);
`endif
    tick();

    // Slot 5 via requester 3, then clear_all marks every ID unused and dirty.
    set_req(3, 4'd5, 14'h0A40);
    exp_grant_q.push_back(3);
    tick();
    req_valid = '0;
    model[5] = 14'h0A40;
    start_commit();
    wait_commit();
    clear_all = 1'b1;
    tick();
    clear_all = 1'b0;
    model[0] = 14'h3D01; model[1] = 14'h3E02; model[2] = 14'h3D12;
    model[3] = 14'h3F03; model[4] = 14'h3C04; model[5] = 14'h3E40;
    model[6] = 14'h3D66; model[7] = 14'h3C00; model[8] = 14'h3C00;
    start_commit();
    wait_commit();

    // Reset in the middle of a commit.
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    for (int s = 0; s < NUM_SLOTS; s++)
      check("midreset_slot", 64'(entity_out[s*ENTITY_W +: ENTITY_W]), 64'h3C00);
    check("midreset_busy", 64'(commit_busy), 64'd0);
    check("midreset_overrun", 64'(overrun), 64'd0);
    check("midreset_bad", 64'(bad_slot_err), 64'd0);
`ifdef ENTITY_SCHED_STATS_EN
    check("midreset_drop", 64'(drop_count), 64'd0);
`endif
    rst_n = 1'b1;
    reset_model();

    // Back in IDLE with rr=0: lone requester 2 is granted and its write commits.
    tick();
    set_req(2, 4'd8, 14'h0888);
    exp_grant_q.push_back(2);
    @(negedge clk);
    check("idle_after_reset", 64'(commit_busy), 64'd0);
    tick();
    req_valid = '0;
    model[8] = 14'h0888;
    start_commit();
    wait_commit();
    repeat (2) tick();

    check("grant_queue_empty", 64'(exp_grant_q.size()), 64'd0);
    check("frame_queue_empty", 64'(exp_frame_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
